// File: rtl/prince_core_sched.sv
`timescale 1ns/1ps
// Purpose: round-robin scheduler sharing one combinational PRINCE core between two requesters, decrypt via alpha-reflection.
// Latency: rsp_valid rises SETTLE_CYCLES cycles after the accept edge; one job in flight, issue interval SETTLE_CYCLES+2.
// Backpressure: result held on rsp_* until rsp_ready; requesters see no ready outside IDLE.
module prince_core_sched #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [63:0] ALPHA         = 64'hc0ac29b7c97c50dd
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_data,
  input  logic [63:0] req0_k0,
  input  logic [63:0] req0_k1,
  input  logic        req0_dec,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_data,
  input  logic [63:0] req1_k0,
  input  logic [63:0] req1_k1,
  input  logic        req1_dec,
  output logic [63:0] core_plaintext,
  output logic [63:0] core_k0,
  output logic [63:0] core_k1,
  input  logic [63:0] core_ciphertext,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_id,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // Counter value on which the core output is considered settled.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        last_grant;

  // Latched job fields; these drive the core for the whole settle window.
  logic        id_q;
  logic [63:0] data_q;
  logic [63:0] k0_q;
  logic [63:0] k1_q;
  logic        dec_q;

  logic        idle;
  logic        grant;
  logic        accept;
  logic        capture;
  logic [63:0] kp;
  logic [63:0] wht;
  logic [63:0] result;

  assign idle = (state == S_IDLE);
  assign busy = !idle;

  // Round-robin pick: a lone requester always wins, a tie goes to whoever did not win last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = idle && req0_valid && !grant;
  assign req1_ready = idle && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign capture    = (state == S_SETTLE) && (cnt == CNT_LAST);

  // k0' derived from k0; decrypt folds (k0 ^ k0') into both the input and the output so the
  // core's own k0/k0' whitening ends up swapped, which together with k1^ALPHA gives the inverse.
  assign kp  = {k0_q[0], k0_q[63:1]} ^ {63'b0, k0_q[63]};
  assign wht = k0_q ^ kp;

  assign core_plaintext = dec_q ? (data_q ^ wht) : data_q;
  assign core_k0        = k0_q;
  assign core_k1        = dec_q ? (k1_q ^ ALPHA) : k1_q;
  assign result         = dec_q ? (core_ciphertext ^ wht) : core_ciphertext;

  // Control FSM: arbitration bookkeeping, settle counter and response handoff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_SETTLE;
            cnt        <= 4'd0;
            last_grant <= grant;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Job register: copies the winner's fields on the accept handshake only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q   <= 1'b0;
      data_q <= 64'd0;
      k0_q   <= 64'd0;
      k1_q   <= 64'd0;
      dec_q  <= 1'b0;
    end else if (accept) begin
      id_q   <= grant;
      data_q <= grant ? req1_data : req0_data;
      k0_q   <= grant ? req1_k0   : req0_k0;
      k1_q   <= grant ? req1_k1   : req0_k1;
      dec_q  <= grant ? req1_dec  : req0_dec;
    end
  end

  // Response register: samples the settled core output, holds it under backpressure and
  // keeps rsp_data after the handoff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 64'd0;
      rsp_id    <= 1'b0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= result;
      rsp_id    <= id_q;
    end else if ((state == S_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prince_core_sched.sv
`timescale 1ns/1ps
// Bench for prince_core_sched: a behavioural PRINCE core closes the loop on core_*,
// expected responses are queued at accept time and checked when rsp_valid/rsp_ready handshake.
module tb_prince_core_sched;

  localparam int          SETTLE = 2;
  localparam logic [63:0] ALPHA  = 64'hc0ac29b7c97c50dd;

  localparam logic [63:0] V_ZERO = 64'h818665aa0d02dfda; // pt 0, k0 0, k1 0
  localparam logic [63:0] V_ONES = 64'h604ae6ca03c20ada; // pt all ones, keys 0
  localparam logic [63:0] V_K0   = 64'h9fb51935fc3df524; // pt 0, k0 all ones, k1 0
  localparam logic [63:0] V_K1   = 64'h78a54cbe737bb7ef; // pt 0, k0 0, k1 all ones
  localparam logic [63:0] V_PT   = 64'hae25ad3ca8fa9ccf; // pt 0123.., k0 0, k1 fedc..
  localparam logic [63:0] PT3    = 64'h0123456789abcdef;
  localparam logic [63:0] K13    = 64'hfedcba9876543210;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_dec;
  logic [63:0] req0_data, req0_k0, req0_k1;
  logic        req1_valid, req1_ready, req1_dec;
  logic [63:0] req1_data, req1_k0, req1_k1;
  logic [63:0] core_plaintext, core_k0, core_k1, core_ciphertext;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [63:0] rsp_data;

  typedef struct {
    logic        id;
    logic [63:0] data;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  bit   acc_log[$];
  int   checks;
  int   errors;
  int   cyc;

  prince_core_sched #(.SETTLE_CYCLES(SETTLE), .ALPHA(ALPHA)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_k0(req0_k0), .req0_k1(req0_k1), .req0_dec(req0_dec),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_k0(req1_k0), .req1_k1(req1_k1), .req1_dec(req1_dec),
    .core_plaintext(core_plaintext), .core_k0(core_k0), .core_k1(core_k1),
    .core_ciphertext(core_ciphertext),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  // ---------------- behavioural PRINCE core ----------------
  function automatic logic [63:0] rc(input int i);
    case (i)
      0:  rc = 64'h0000000000000000;
      1:  rc = 64'h13198a2e03707344;
      2:  rc = 64'ha4093822299f31d0;
      3:  rc = 64'h082efa98ec4e6c89;
      4:  rc = 64'h452821e638d01377;
      5:  rc = 64'hbe5466cf34e90c6c;
      6:  rc = 64'h7ef84f78fd955cb1;
      7:  rc = 64'h85840851f1ac43aa;
      8:  rc = 64'hc882d32f25323c54;
      9:  rc = 64'h64a51195e0e3610d;
      10: rc = 64'hd3b5a399ca0c2399;
      default: rc = 64'hc0ac29b7c97c50dd;
    endcase
  endfunction

  function automatic logic [63:0] sbox(input logic [63:0] x, input bit inv);
    logic [3:0]  fw [0:15];
    logic [3:0]  bw [0:15];
    logic [63:0] y;
    fw = '{4'hb,4'hf,4'h3,4'h2,4'ha,4'hc,4'h9,4'h1,4'h6,4'h7,4'h8,4'h0,4'he,4'h5,4'hd,4'h4};
    bw = '{4'hb,4'h7,4'h3,4'h2,4'hf,4'hd,4'h8,4'h9,4'ha,4'h6,4'h4,4'h0,4'h5,4'he,4'hc,4'h1};
    y = '0;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = inv ? bw[x[4*i +: 4]] : fw[x[4*i +: 4]];
    return y;
  endfunction

  // M' layer: chunks 3 and 0 use M0, chunks 2 and 1 use M1.
  function automatic logic [63:0] mprime(input logic [63:0] x);
    logic [63:0] y;
    int          excl;
    logic        p;
    y = '0;
    for (int j = 0; j < 4; j++)
      for (int r = 0; r < 4; r++)
        for (int b = 0; b < 4; b++) begin
          excl = ((j == 1) || (j == 2)) ? ((b - r) & 3) : ((b + 3 - r) & 3);
          p = 1'b0;
          for (int c = 0; c < 4; c++) if (c != excl) p = p ^ x[16*j + 4*c + b];
          y[16*j + 4*r + b] = p;
        end
    return y;
  endfunction

  function automatic logic [63:0] srows(input logic [63:0] x, input bit inv);
    logic [63:0] mask, row, y;
    mask = 64'hf000f000f000f000;
    y = '0;
    for (int r = 0; r < 4; r++) begin
      row = x & (mask >> (4*r));
      if (!inv) y = y | (row << (16*r)) | (row >> (64 - 16*r));
      else      y = y | (row >> (16*r)) | (row << (64 - 16*r));
    end
    return y;
  endfunction

  function automatic logic [63:0] prince_enc(input logic [63:0] pt, k0, k1);
    logic [63:0] s, k0p;
    k0p = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};
    s = pt ^ k0 ^ k1 ^ rc(0);
    for (int i = 1; i <= 5; i++) s = srows(mprime(sbox(s, 0)), 0) ^ rc(i) ^ k1;
    s = sbox(mprime(sbox(s, 0)), 1);
    for (int i = 6; i <= 10; i++) s = sbox(mprime(srows(s ^ rc(i) ^ k1, 1)), 1);
    s = s ^ rc(11) ^ k1;
    return s ^ k0p;
  endfunction

  assign core_ciphertext = prince_enc(core_plaintext, core_k0, core_k1);

  // ---------------- clock, cycle count, watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Present a job from requester n (entered just after a rising edge), wait for its ready,
  // queue the expected response, and drop valid after the accept edge.
  task automatic issue(input bit n, input logic [63:0] d, k0, k1, input bit dec,
                       input logic [63:0] exp);
    int   budget;
    bit   got;
    exp_t e;
    if (n) begin
      req1_valid = 1'b1; req1_data = d; req1_k0 = k0; req1_k1 = k1; req1_dec = dec;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_k0 = k0; req0_k1 = k1; req0_dec = dec;
    end
    budget = 0;
    got    = 1'b0;
    while (!got && budget < 100) begin
      @(negedge clk);
      if ((n ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
      else budget++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_req%0d: no ready within 100 cycles, expected acceptance", n);
    end else begin
      e.id   = n;
      e.data = exp;
      e.acc  = cyc + 1;
      exp_q.push_back(e);
      acc_log.push_back(n);
      @(posedge clk);
      #1;
    end
    if (n) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- response monitor ----------------
  initial begin : monitor
    logic prev_vld;
    exp_t e;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (req0_valid && req1_valid) begin
        checks++;
        if (req0_ready && req1_ready) begin
          errors++;
          $display("FAIL one_ready: req0_ready=1 req1_ready=1, expected at most one");
        end
      end
      if (rsp_valid && !prev_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_rsp: rsp_valid rose (data %h), expected no response", rsp_data);
        end else if (cyc - exp_q[0].acc != SETTLE) begin
          errors++;
          $display("FAIL latency: %0d cycles, expected %0d", cyc - exp_q[0].acc, SETTLE);
        end
      end
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk1("rsp_id", rsp_id, e.id);
      end
      prev_vld = rsp_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    bit exp_seq [4];
    int n;
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_k0 = '0; req0_k1 = '0; req0_dec = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_k0 = '0; req1_k1 = '0; req1_dec = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    chk1("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_core_pt", core_plaintext, 64'd0);
    chk("reset_core_k1", core_k1, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesters contend right after reset: grants must alternate 0,1,0,1.
    fork
      begin
        issue(1'b0, 64'd0, 64'd0, 64'd0, 1'b0, V_ZERO);
        issue(1'b0, 64'd0, '1,    64'd0, 1'b0, V_K0);
      end
      begin
        issue(1'b1, '1,    64'd0, 64'd0, 1'b0, V_ONES);
        issue(1'b1, 64'd0, 64'd0, '1,    1'b0, V_K1);
      end
    join
    drain();
    chk("rr_count", 64'(acc_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) chk1("rr_order", acc_log[i], exp_seq[i]);

    // Lone encrypt with non-trivial plaintext and k1.
    issue(1'b0, PT3, 64'd0, K13, 1'b0, V_PT);
    drain();

    // Decrypt with zero keys: core sees data unchanged and k1 = ALPHA.
    issue(1'b0, V_ZERO, 64'd0, 64'd0, 1'b1, 64'd0);
    @(negedge clk);
    chk1("dec_busy", busy, 1'b1);
    chk("dec_core_k1", core_k1, ALPHA);
    chk("dec_core_pt", core_plaintext, V_ZERO);
    drain();

    // Decrypt with k0 all ones: whitening correction k0^k0' = 1.
    issue(1'b1, V_K0, '1, 64'd0, 1'b1, 64'd0);
    @(negedge clk);
    chk("dec2_core_pt", core_plaintext, V_K0 ^ 64'd1);
    chk("dec2_core_k0", core_k0, '1);
    drain();

    issue(1'b1, V_PT, 64'd0, K13, 1'b1, PT3);
    drain();

    // Backpressure: result held for 10 cycles while another request waits.
    rsp_ready = 1'b0;
    issue(1'b1, '1, 64'd0, 64'd0, 1'b0, V_ONES);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("bp_valid_seen", rsp_valid, 1'b1);
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_data = '0; req0_k0 = '0; req0_k1 = '0; req0_dec = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_data, V_ONES);
      chk1("bp_hold_id", rsp_id, 1'b1);
      chk1("bp_req0_ready", req0_ready, 1'b0);
      chk1("bp_req1_ready", req1_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("bp_after_valid", rsp_valid, 1'b0);
    chk1("bp_after_busy", busy, 1'b0);
    chk("bp_after_data_kept", rsp_data, V_ONES);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Reset during SETTLE at cnt=1: job dropped, everything cleared.
    req0_valid = 1'b1; req0_data = PT3; req0_k0 = 64'h1111111111111111;
    req0_k1 = K13; req0_dec = 1'b1;
    @(negedge clk);
    chk1("rst_setup_ready", req0_ready, 1'b1);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_setup_core_k1", core_k1, K13 ^ ALPHA);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_core_pt", core_plaintext, 64'd0);
    chk("rst_core_k0", core_k0, 64'd0);
    chk("rst_core_k1", core_k1, 64'd0);
    repeat (6) @(negedge clk);
    chk1("rst_no_rsp", rsp_valid, 1'b0);
    @(posedge clk);
    #1;

    // First tie after reset goes to requester 0 again.
    acc_log.delete();
    fork
      issue(1'b0, 64'd0, 64'd0, 64'd0, 1'b0, V_ZERO);
      issue(1'b1, '1,    64'd0, 64'd0, 1'b0, V_ONES);
    join
    drain();
    chk("post_rst_count", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() > 0) chk1("post_rst_first_grant", acc_log[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prince_core_sched.md
Name: prince_core_sched

Overview:
- Shares one combinational PRINCE encryption core (inputs plaintext/k0/k1, output ciphertext) between two requesters.
- Round-robin arbitration between the requesters.
- Registers the winning request and holds the core inputs stable for a fixed settle window.
- Captures the result and returns it with a requester ID over a valid/ready response channel.
- Configures decryption with the core unchanged, using PRINCE alpha-reflection (key tweak plus whitening correction).

Parameters:
- SETTLE_CYCLES, 2, cycles the core inputs are held before the output is sampled. Legal range 1..15.
- ALPHA, 64'hc0ac29b7c97c50dd, PRINCE reflection constant.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0_valid  input  1  requester 0 has a job.
- req0_ready  output  1  requester 0 job accepted this cycle if valid.
- req0_data  input  64  plaintext (encrypt) or ciphertext (decrypt).
- req0_k0  input  64  whitening key k0.
- req0_k1  input  64  core key k1.
- req0_dec  input  1  1 = decrypt, 0 = encrypt.
- req1_valid, req1_ready, req1_data, req1_k0, req1_k1, req1_dec: same as requester 0, for requester 1.
- core_plaintext  output  64  drives core plaintext input.
- core_k0  output  64  drives core k0.
- core_k1  output  64  drives core k1.
- core_ciphertext  input  64  core result, combinational from the core_* outputs.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  64  result block.
- rsp_id  output  1  requester that owns the result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All state updates on rising clk. When rst_n=0 at an edge, everything below resets, overriding any in-flight job (which is dropped, no response):
  - state=IDLE, cnt=0, last_grant=1 (requester 0 wins the first tie).
  - Registered data/key fields = 0, so core_* outputs = 0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - grant = requester 0 if only req0_valid; requester 1 if only req1_valid.
  - If both are valid, grant = the requester that is not last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid. Combinational; at most one ready per cycle.
  - On handshake: latch id, data, k0, k1, dec; last_grant<=id; cnt<=0; go to SETTLE. The losing requester stays pending with no ready.
- Core drive, from latched fields:
  - Encrypt (dec=0): core_plaintext=data, core_k0=k0, core_k1=k1.
  - Decrypt (dec=1): kp = {k0[0],k0[63:1]} ^ {63'b0,k0[63]}; core_plaintext=data^k0^kp; core_k0=k0; core_k1=k1^ALPHA.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, capture rsp_data = core_ciphertext, XORed with (k0^kp) if dec=1, else unmodified.
  - On that capture: rsp_id<=id, rsp_valid<=1, go to RESP.
  - Latency from accept edge to rsp_valid high is SETTLE_CYCLES+1 edges... precisely, rsp_valid rises SETTLE_CYCLES cycles after the accept edge.
- RESP:
  - Hold rsp_data/rsp_id stable while rsp_valid=1 && rsp_ready=0 (backpressure, unbounded).
  - On rsp_valid && rsp_ready: rsp_valid<=0, go to IDLE.
  - No new request is accepted in the same cycle; minimum issue interval is SETTLE_CYCLES+2 cycles.
- Request inputs are ignored outside IDLE. Requesters hold valid and fields stable until ready.
- rsp_data is 0 after reset until the first capture. rsp_data keeps its last value after handoff.

Test Plan:
- Encrypt vector 1: req0 data=0, k0=0, k1=0, dec=0 -> one response, rsp_id=0, rsp_data=64'h818665aa0d02dfda, rsp_valid rising SETTLE_CYCLES cycles after accept.
- Encrypt vector 2: req1 data=64'hffffffffffffffff, k0=0, k1=0, dec=0 -> rsp_id=1, rsp_data=64'h604ae6ca03c20ada.
- Decrypt: req0 data=64'h818665aa0d02dfda, keys 0, dec=1 -> rsp_data=0; core_k1 observed = ALPHA during SETTLE.
- Simultaneous requests right after reset, both valid held -> grants alternate 0,1,0,1; rsp_id sequence is 0,1,0,1; never two readys in one cycle.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid/rsp_data/rsp_id stable; both reqN_ready stay 0; release -> one transfer, then IDLE.
- Reset in SETTLE: assert rst_n=0 for one cycle at cnt=1 -> next cycle state IDLE, rsp_valid=0, core_*=0, no response emitted; next request from req0 wins the arbitration.
